// File: rtl/uart_pkg.sv
// UART frame bit-select codes shared by the transmit mux and the upstream bit counter.
`timescale 1ns/1ps
package uart_pkg;

    localparam logic [3:0] SEL_IDLE  = 4'd0;
    localparam logic [3:0] SEL_START = 4'd1;
    localparam logic [3:0] SEL_D0    = 4'd2;
    localparam logic [3:0] SEL_D1    = 4'd3;
    localparam logic [3:0] SEL_D2    = 4'd4;
    localparam logic [3:0] SEL_D3    = 4'd5;
    localparam logic [3:0] SEL_D4    = 4'd6;
    localparam logic [3:0] SEL_D5    = 4'd7;
    localparam logic [3:0] SEL_D6    = 4'd8;
    localparam logic [3:0] SEL_D7    = 4'd9;
    localparam logic [3:0] SEL_PAR   = 4'd10;
    localparam logic [3:0] SEL_STOP  = 4'd11;

    // True when sel addresses one of the eight payload bits.
    function automatic logic is_data_sel(input logic [3:0] sel);
        return (sel >= SEL_D0) && (sel <= SEL_D7);
    endfunction

endpackage

// File: rtl/max_tx.sv
// UART transmit bit mux: drives the line level for the frame bit chosen by sel.
// Latency: 1 cycle from sel/data to Tx (registered, glitch-free output).
// Backpressure: none; sel is sampled every edge, upstream holds data for the frame.
`timescale 1ns/1ps
module max_tx
    import uart_pkg::*;
#(
    parameter logic PARITY_ODD = 1'b0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic [3:0] sel,
    output logic       Tx
);

    logic       nxt;
    logic [2:0] bit_idx;

    assign bit_idx = 3'(sel - SEL_D0);

    // Unused codes 12..15 fall through to the idle level so the line stays safe.
    always_comb begin
        nxt = IDLE_LEVEL;
        case (sel)
            SEL_IDLE:  nxt = IDLE_LEVEL;
            SEL_START: nxt = ~IDLE_LEVEL;
            SEL_PAR:   nxt = (^data) ^ PARITY_ODD;
            SEL_STOP:  nxt = IDLE_LEVEL;
            default: begin
                if (is_data_sel(sel)) begin
                    nxt = data[bit_idx];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Tx <= IDLE_LEVEL;
        end else begin
            Tx <= nxt;
        end
    end

endmodule

// File: tb/tb_max_tx.sv
// Directed and random checks of max_tx (even and odd parity instances) against a frame model.
`timescale 1ns/100ps
module tb_max_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [3:0] sel;
    logic       tx_even;
    logic       tx_odd;

    int errors = 0;
    int checks = 0;

    max_tx #(.PARITY_ODD(1'b0), .IDLE_LEVEL(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .sel  (sel),
        .Tx   (tx_even)
    );

    max_tx #(.PARITY_ODD(1'b1), .IDLE_LEVEL(1'b1)) dut_odd (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .sel  (sel),
        .Tx   (tx_odd)
    );

    always #2 clk = ~clk;

    // Frame model: position in the frame -> line level, built from the byte directly.
    function automatic logic ref_tx(input logic [7:0] d, input logic [3:0] s, input logic odd);
        int pos;
        pos = int'(s);
        if (pos == 0)               return 1'b1;
        if (pos == 1)               return 1'b0;
        if (pos >= 2 && pos <= 9)   return logic'((int'(d) >> (pos - 2)) % 2);
        if (pos == 10)              return logic'(($countones(d) + (odd ? 1 : 0)) % 2);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs away from the active edge, then sample just after it.
    task automatic step(input logic [7:0] d, input logic [3:0] s);
        @(negedge clk);
        data = d;
        sel  = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [11:0] exp_seq;
        logic [7:0]  rd;
        logic [3:0]  rs;

        // Reset is asynchronous: Tx is idle before any clock edge.
        rst  = 1'b1;
        data = 8'hFF;
        sel  = 4'd1;
        #1;
        check("reset_async_even", tx_even, 1'b1);
        check("reset_async_odd",  tx_odd,  1'b1);
        @(posedge clk);
        #1;
        check("reset_held_clocked", tx_even, 1'b1);

        @(negedge clk);
        sel = 4'd0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_idle", tx_even, 1'b1);

        // Full frame sweep for 0xA5, even parity.
        exp_seq = 12'b1010_1001_0101;
        for (int i = 0; i < 12; i++) begin
            step(8'hA5, 4'(i));
            check($sformatf("sweep_a5_sel%0d", i), tx_even, exp_seq[11 - i]);
        end

        // Odd parity instance.
        step(8'h07, 4'd10);
        check("odd_par_07", tx_odd, 1'b0);
        check("even_par_07", tx_even, 1'b1);
        step(8'h03, 4'd10);
        check("odd_par_03", tx_odd, 1'b1);
        check("even_par_03", tx_even, 1'b0);

        // Unused codes must sit at the idle level even with an all-zero byte.
        for (int c = 12; c < 16; c++) begin
            step(8'h00, 4'(c));
            check($sformatf("unused_sel%0d", c), tx_even, 1'b1);
        end

        // Mid-frame reset between edges, then release.
        step(8'h00, 4'd1);
        check("start_before_rst", tx_even, 1'b0);
        rst = 1'b1;
        #0.5;
        check("rst_between_edges", tx_even, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_start", tx_even, 1'b0);

        // Random pairs against the frame model, both parity settings.
        for (int n = 0; n < 20; n++) begin
            rd = 8'($urandom);
            rs = 4'($urandom_range(0, 15));
            step(rd, rs);
            check($sformatf("rand%0d_even d=%h s=%0d", n, rd, rs), tx_even, ref_tx(rd, rs, 1'b0));
            check($sformatf("rand%0d_odd d=%h s=%0d", n, rd, rs),  tx_odd,  ref_tx(rd, rs, 1'b1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
